// File: rtl/xor_arbiter.sv
// xor_arbiter: round-robin access to one shared WIDTH-bit XOR bank for
// NUM_REQ requesters, with a tagged valid/ready response channel.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   req_valid  - per-requester operand-pair pending
//   req_a/b    - packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready  - one-hot accept strobe (IDLE only, never during reset)
//   rsp_valid  - result held until rsp_ready
//   rsp_data   - a ^ b of the granted pair
//   rsp_id     - index of the requester that produced rsp_data
//   rsp_ready  - consumer accepts the response
//   busy       - high whenever a transaction is held
//   op_count   - completed responses, wraps at 16 bits
//
// xor_gate: single-bit XOR cell used to build the shared bank.

module xor_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

module xor_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  input  logic                     rsp_ready,
  output logic                     busy,
  output logic [15:0]              op_count
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] scan_idx;
  logic            win_found;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] bank_out;

  // Round-robin scan upward from ptr; ID_W-bit addition wraps modulo
  // NUM_REQ because NUM_REQ is a power of two.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = ptr + ID_W'(k);
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && !rst && win_found)
      req_ready[win_id] = 1'b1;
  end

  assign busy = (state != IDLE);

  for (genvar j = 0; j < WIDTH; j++) begin : g_bank
    xor_gate u_xor (
      .a (op_a[j]),
      .b (op_b[j]),
      .y (bank_out[j])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_id    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            op_a   <= req_a[win_id*WIDTH +: WIDTH];
            op_b   <= req_b[win_id*WIDTH +: WIDTH];
            gnt_id <= win_id;
            state  <= CALC;
          end
        end
        CALC: begin
          rsp_data  <= bank_out;
          rsp_id    <= gnt_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 16'd1;
            ptr       <= gnt_id + ID_W'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
